// File: rtl/cordic_magnitude.sv
// cordic_magnitude: fully pipelined vectoring-mode CORDIC returning sqrt(x^2 + y^2)
module cordic_magnitude #(
  parameter int Q_I  = 15,
  parameter int Q_F  = 16,
  parameter int ITER = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             valid_i,
  input  logic [Q_I+Q_F:0] x_data_i,
  input  logic [Q_I+Q_F:0] y_data_i,
  output logic             valid_o,
  output logic [Q_I+Q_F:0] data_o
);
  localparam int WIDTH = Q_I + Q_F + 1;
  localparam int IW = WIDTH + 2;
  localparam int KF = Q_F + 2;
  localparam int PW = IW + KF + 2;
  localparam logic signed [KF+1:0] K = (KF+2)'($rtoi(0.6072529350088813 * (2.0 ** KF) + 0.5));
  localparam logic signed [PW-1:0] MAX = PW'((64'd1 << (WIDTH - 1)) - 64'd1);
  logic signed [IW-1:0] xs [0:ITER];
  logic signed [IW-1:0] ys [0:ITER];
  logic [ITER:0] vs;
  logic signed [IW-1:0] xe, ye;
  logic signed [PW-1:0] prod_q, shr;
  logic vp;
  // sign-extend into the guarded internal width before any negation
  always_comb begin
    xe = {{2{x_data_i[WIDTH-1]}}, x_data_i};
    ye = {{2{y_data_i[WIDTH-1]}}, y_data_i};
    shr = prod_q >>> KF;
  end
  // input register with 180 degree pre-rotation, then one register per micro-rotation
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vs <= '0;
      for (int i = 0; i <= ITER; i++) begin
        xs[i] <= '0;
        ys[i] <= '0;
      end
    end else begin
      vs <= {vs[ITER-1:0], valid_i};
      xs[0] <= xe[IW-1] ? -xe : xe;
      ys[0] <= xe[IW-1] ? -ye : ye;
      for (int i = 0; i < ITER; i++) begin
        xs[i+1] <= ys[i][IW-1] ? xs[i] - (ys[i] >>> i) : xs[i] + (ys[i] >>> i);
        ys[i+1] <= ys[i][IW-1] ? ys[i] + (xs[i] >>> i) : ys[i] - (xs[i] >>> i);
      end
    end
  end
  // gain compensation multiply, then scale down with saturation into the output register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prod_q  <= '0;
      vp      <= 1'b0;
      valid_o <= 1'b0;
      data_o  <= '0;
    end else begin
      prod_q  <= PW'(xs[ITER]) * PW'(K);
      vp      <= vs[ITER];
      valid_o <= vp;
      data_o  <= shr[PW-1] ? '0 : (shr > MAX) ? {1'b0, {(WIDTH-1){1'b1}}} : shr[WIDTH-1:0];
    end
  end
endmodule

// File: tb/tb_cordic_magnitude.sv
// tb_cordic_magnitude: scoreboard bench comparing the CORDIC magnitude against a real-valued sqrt model
module tb_cordic_magnitude;
  localparam int W = 32;
  localparam int ITER = 16;
  localparam int LAT = ITER + 2;
  localparam real MAXV = 2147483647.0;
  localparam longint ONE = 64'sd65536;

  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;
  logic valid_i = 1'b0;
  logic [W-1:0] x_data_i = '0;
  logic [W-1:0] y_data_i = '0;
  logic valid_o;
  logic [W-1:0] data_o;

  cordic_magnitude dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .valid_i(valid_i),
    .x_data_i(x_data_i), .y_data_i(y_data_i),
    .valid_o(valid_o), .data_o(data_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    real mag;
    int  due;
    int  id;
  } exp_t;

  exp_t q[$];
  int ec = 0;
  int nid = 0;
  int checks = 0;
  int fails = 0;

  always @(posedge clk_i) ec++;

  task automatic drive(input bit v, input longint x, input longint y);
    exp_t e;
    @(posedge clk_i);
    #1;
    valid_i  = v;
    x_data_i = W'(x);
    y_data_i = W'(y);
    if (v) begin
      e.mag = $sqrt(real'(x) * real'(x) + real'(y) * real'(y));
      e.due = ec + 1 + LAT;
      e.id  = nid++;
      q.push_back(e);
    end
  endtask

  exp_t cur;
  logic due;
  real expv, tol, err;

  always @(negedge clk_i) begin
    if (!rst_ni) begin
      checks++;
      if (valid_o !== 1'b0 || data_o !== '0) begin
        fails++;
        $display("FAIL reset_out: valid_o=%b data_o=%h, required 0/0", valid_o, data_o);
      end
    end else begin
      due = (q.size() > 0) && (q[0].due == ec);
      if (valid_o || due) begin
        checks++;
        if (!(valid_o && due)) begin
          fails++;
          $display("FAIL valid_timing: cycle %0d valid_o=%b, required %b", ec, valid_o, due);
          if (due) void'(q.pop_front());
        end else begin
          cur  = q.pop_front();
          expv = (cur.mag > MAXV) ? MAXV : cur.mag;
          tol  = cur.mag / 16384.0 + 4.0;
          err  = real'(data_o) - expv;
          if (err < 0.0) err = -err;
          if (err > tol) begin
            fails++;
            $display("FAIL magnitude #%0d: data_o=%0d, required %0.1f +/- %0.1f", cur.id, data_o, expv, tol);
          end
        end
      end
    end
  end

  task automatic drain();
    int n = 0;
    while (q.size() > 0 && n < 200) begin
      @(posedge clk_i);
      n++;
    end
    checks++;
    if (q.size() > 0) begin
      fails++;
      $display("FAIL drain_timeout: %0d results outstanding, required 0", q.size());
      q.delete();
    end
    repeat (LAT + 4) @(posedge clk_i);
  endtask

  longint rx, ry;
  real rm;

  initial begin
    valid_i  = 1'b1;
    x_data_i = W'(3 * ONE);
    y_data_i = W'(4 * ONE);
    repeat (2) @(posedge clk_i);
    #2;
    rst_ni  = 1'b1;
    valid_i = 1'b0;
    repeat (LAT + 6) @(posedge clk_i);

    drive(1, 3 * ONE, 4 * ONE);
    drive(0, 0, 0);
    drain();

    drive(1, -3 * ONE, -4 * ONE);
    drive(1, -3 * ONE, 4 * ONE);
    drive(1, 3 * ONE, -4 * ONE);
    drive(1, 0, 0);
    drive(1, 0, -(5 * ONE) / 2);
    drive(1, -64'sd2147483648, 0);
    drive(1, -64'sd2147483648, -64'sd2147483648);
    drive(1, 64'sd2147483647, 64'sd2147483647);
    drive(0, 0, 0);
    drain();

    for (int k = 1; k <= 1024; k++) drive(1, k * ONE, k * ONE);
    drive(0, 0, 0);
    drain();

    drive(1, 7 * ONE, 24 * ONE);
    drive(0, 99 * ONE, 1 * ONE);
    drive(1, -8 * ONE, 15 * ONE);
    drive(1, 20 * ONE, -21 * ONE);
    drive(0, 5 * ONE, 5 * ONE);
    for (int k = 0; k < 20; k++) drive(k % 2 == 0, (k + 2) * ONE, -(k + 1) * ONE);
    drive(0, 0, 0);
    drain();

    for (int k = 0; k < 300; k++) begin
      rx = longint'($urandom_range(0, 32'h7FFF_FFFF)) - 64'sd1073741824;
      ry = longint'($urandom_range(0, 32'h7FFF_FFFF)) - 64'sd1073741824;
      rm = $sqrt(real'(rx) * real'(rx) + real'(ry) * real'(ry));
      if (rm < 1048576.0) rx = 64'sd1048576;
      drive($urandom_range(0, 3) != 0, rx, ry);
    end
    drive(0, 0, 0);
    drain();

    for (int k = 1; k <= 10; k++) drive(1, k * ONE, 2 * k * ONE);
    @(posedge clk_i);
    #3;
    rst_ni  = 1'b0;
    valid_i = 1'b0;
    q.delete();
    repeat (2) @(posedge clk_i);
    #2;
    rst_ni = 1'b1;
    repeat (LAT + 6) @(posedge clk_i);
    drive(1, 6 * ONE, 8 * ONE);
    drive(1, -12 * ONE, 5 * ONE);
    drive(0, 0, 0);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
